// File: rtl/fifo_wr_arbiter_if.sv
// Interface bundling the requester handshakes, the FIFO write port and the
// arbiter status outputs. The arbiter connects through the slave modport;
// the producers/FIFO side (or a testbench) uses the master modport.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  localparam int GW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            ReqValid;
  logic [NUM_REQ*DATA_WIDTH-1:0] ReqData;
  logic [NUM_REQ-1:0]            ReqReady;
  logic                          FifoWriteEn;
  logic [DATA_WIDTH-1:0]         FifoDataIn;
  logic                          FifoFull_;
  logic                          FifoHalfFull_;
  logic                          FifoError;
  logic [GW-1:0]                 GrantId;
  logic                          Busy;
  logic                          ErrorSticky;

  modport slave (
    input  ReqValid, ReqData, FifoFull_, FifoHalfFull_, FifoError,
    output ReqReady, FifoWriteEn, FifoDataIn, GrantId, Busy, ErrorSticky
  );

  modport master (
    output ReqValid, ReqData, FifoFull_, FifoHalfFull_, FifoError,
    input  ReqReady, FifoWriteEn, FifoDataIn, GrantId, Busy, ErrorSticky
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one FIFO write port among
// NUM_REQ producers, with bounded bursts of up to MAX_BURST words per grant.
// Optional macro FIFO_ARB_WMARK_EN: while the FIFO reports half full, only
// requester 0 may be granted and bursts of other requesters are cut short.
//
// Handshake: a word moves from requester i when ReqValid[i] & ReqReady[i]
// are both high at a rising Clock edge. ReqReady is only ever high for the
// granted requester, and only while the FIFO is not full and no error has been
// latched. FifoWriteEn mirrors that transfer in the same cycle.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input logic          Clock,
  input logic          Reset_,
  fifo_wr_arbiter_if.slave bus
);
  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = 4;

  typedef enum logic {IDLE, BURST} state_t;

  state_t               state_q, state_d;
  logic [GW-1:0]        rr_q, rr_d;
  logic [GW-1:0]        grant_q, grant_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 err_q, err_d;

  logic                 pick_found;
  logic [GW-1:0]        pick_id;
  logic [NUM_REQ-1:0]   ready_vec;
  logic                 wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                 g_valid;
  logic [DATA_WIDTH-1:0] g_data;
  logic                 ready;
  logic                 xfer;
  logic                 burst_end;
  logic                 wmark_cut;
  logic [GW-1:0]        next_rr;
  int                   idx;

`ifndef FIFO_ARB_WMARK_EN
  logic unused_half_full;
  assign unused_half_full = bus.FifoHalfFull_;
`endif

  // Pick the first valid requester at or after the round-robin pointer.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    idx        = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_q) + k) % NUM_REQ;
      if (!pick_found && bus.ReqValid[idx]) begin
        pick_found = 1'b1;
        pick_id    = GW'(idx);
      end
    end
`ifdef FIFO_ARB_WMARK_EN
    // FIFO past the watermark: only requester 0 may win.
    if (!bus.FifoHalfFull_) begin
      pick_found = bus.ReqValid[0];
      pick_id    = '0;
    end
`endif
  end

  // Next-state and output decode for the IDLE/BURST controller.
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    grant_d   = grant_q;
    cnt_d     = cnt_q;
    ready_vec = '0;
    wr_en     = 1'b0;
    wr_data   = '0;
    burst_end = 1'b0;
    wmark_cut = 1'b0;
    next_rr   = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
    g_valid   = bus.ReqValid[grant_q];
    g_data    = bus.ReqData[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
    ready     = bus.FifoFull_ & ~err_q;
    xfer      = 1'b0;
`ifdef FIFO_ARB_WMARK_EN
    wmark_cut = (grant_q != '0) && !bus.FifoHalfFull_;
`endif
    case (state_q)
      IDLE: begin
        if (pick_found && !err_q) begin
          grant_d = pick_id;
          cnt_d   = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        xfer               = g_valid & ready;
        ready_vec[grant_q] = ready;
        wr_en              = xfer;
        wr_data            = xfer ? g_data : '0;
        if (xfer) cnt_d = cnt_q + 1'b1;
        burst_end = (xfer && (cnt_q == CW'(MAX_BURST - 1))) || !g_valid || wmark_cut;
        if (err_q) begin
          state_d = IDLE;
        end else if (burst_end) begin
          state_d = IDLE;
          rr_d    = next_rr;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Error latch: any FifoError cycle sets it until reset.
  always_comb begin
    err_d = err_q | bus.FifoError;
  end

  // State, pointer, grant, count and error registers.
  always_ff @(posedge Clock or negedge Reset_) begin
    if (!Reset_) begin
      state_q <= IDLE;
      rr_q    <= '0;
      grant_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign bus.ReqReady    = ready_vec;
  assign bus.FifoWriteEn = wr_en;
  assign bus.FifoDataIn  = wr_data;
  assign bus.GrantId     = grant_q;
  assign bus.Busy        = (state_q == BURST);
  assign bus.ErrorSticky = err_q;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter: producers are modelled as word queues, the
// FIFO as an occupancy counter of depth 8, and the expected write stream is
// predicted by a transaction-level round-robin model.
module tb_fifo_wr_arbiter;
  localparam int NUM_REQ = 4;
  localparam int DW      = 8;
  localparam int MAXB    = 4;
  localparam int DEPTH   = 8;
  localparam int GW      = $clog2(NUM_REQ);

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DW)) bus ();

  fifo_wr_arbiter #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .MAX_BURST(MAXB)) dut (
    .Clock  (clk),
    .Reset_ (rst_n),
    .bus    (bus)
  );

  // ---------------- bench state ----------------
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] prod_q [NUM_REQ][$];
  logic [DW-1:0] exp_q[$];
  int            exp_g_q[$];
  int            wr_cyc_q[$];
  int            wr_gnt_q[$];
  logic [DW-1:0] wr_dat_q[$];
  int   fifo_cnt = 0;
  int   m_rr     = 0;
  int   err_cyc  = -1;
  logic hf_n     = 1'b1;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    bus.ReqValid      = '0;
    bus.ReqData       = '0;
    bus.FifoFull_     = 1'b1;
    bus.FifoHalfFull_ = 1'b1;
    bus.FifoError     = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    for (int i = 0; i < NUM_REQ; i++) prod_q[i].delete();
    fifo_cnt = 0;
    m_rr     = 0;
    err_cyc  = -1;
    hf_n     = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drive_inputs(input int cyc);
    logic [DW-1:0] w;
    for (int i = 0; i < NUM_REQ; i++) begin
      w = '0;
      if (prod_q[i].size() > 0) w = prod_q[i][0];
      bus.ReqValid[i]          = (prod_q[i].size() > 0);
      bus.ReqData[i*DW +: DW]  = w;
    end
    bus.FifoFull_ = (fifo_cnt < DEPTH);
    bus.FifoError = (cyc == err_cyc);
`ifdef FIFO_ARB_WMARK_EN
    bus.FifoHalfFull_ = hf_n;
`else
    bus.FifoHalfFull_ = 1'($urandom_range(1));
`endif
  endtask

  // Transaction-level round robin: each grant takes min(MAX_BURST, remaining)
  // words from the first non-empty producer at or after the pointer.
  task automatic build_expected();
    int rem [NUM_REQ];
    int off [NUM_REQ];
    int rr, g, n;
    bool_loop: begin end
    exp_q.delete();
    exp_g_q.delete();
    rr = m_rr;
    for (int i = 0; i < NUM_REQ; i++) begin
      rem[i] = prod_q[i].size();
      off[i] = 0;
    end
    forever begin
      g = -1;
      for (int k = 0; k < NUM_REQ; k++)
        if (g < 0 && rem[(rr + k) % NUM_REQ] > 0) g = (rr + k) % NUM_REQ;
      if (g < 0) break;
      n = (rem[g] < MAXB) ? rem[g] : MAXB;
      for (int j = 0; j < n; j++) begin
        exp_q.push_back(prod_q[g][off[g] + j]);
        exp_g_q.push_back(g);
      end
      off[g] += n;
      rem[g] -= n;
      rr = (g + 1) % NUM_REQ;
    end
    m_rr = rr;
  endtask

  // Cycle loop: drive at negedge, check 1ns later, model the edge afterwards.
  task automatic run_stream(input int max_cyc, input int read_pct, input bit drain);
    int cyc, tail, hs, nready, c0;
    bit done, empty;
    logic [DW-1:0] e;
    int eg;
    cyc = 0; tail = 0; done = 1'b0;
    wr_cyc_q.delete(); wr_gnt_q.delete(); wr_dat_q.delete();
    if (drain) build_expected();
    while (!done) begin
      @(negedge clk);
      drive_inputs(cyc);
      #1;
      hs = -1; nready = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (bus.ReqReady[i]) nready++;
        if (bus.ReqReady[i] && bus.ReqValid[i]) hs = i;
      end
      checks++;
      if (nready > 1) begin errors++; $display("FAIL ready_onehot: ReqReady=%b", bus.ReqReady); end
      checks++;
      if (nready > 0 && fifo_cnt >= DEPTH) begin errors++; $display("FAIL ready_when_full: ReqReady=%b required 0", bus.ReqReady); end
      checks++;
      if (bus.FifoWriteEn !== (hs >= 0)) begin errors++; $display("FAIL write_en: got %b required %b (cyc %0d)", bus.FifoWriteEn, (hs >= 0), cyc); end
      c0 = fifo_cnt;
      if (hs >= 0) begin
        checks++;
        if (bus.FifoDataIn !== prod_q[hs][0]) begin errors++; $display("FAIL data_in: got %h required %h", bus.FifoDataIn, prod_q[hs][0]); end
        checks++;
        if (bus.GrantId !== GW'(hs)) begin errors++; $display("FAIL grant_id: got %0d required %0d", bus.GrantId, hs); end
        if (drain) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++; $display("FAIL extra_write: got %h from req %0d, none expected", bus.FifoDataIn, hs);
          end else begin
            e = exp_q.pop_front(); eg = exp_g_q.pop_front();
            if (bus.FifoDataIn !== e || hs != eg) begin
              errors++; $display("FAIL scoreboard: got %h/req%0d required %h/req%0d", bus.FifoDataIn, hs, e, eg);
            end
          end
        end
        wr_cyc_q.push_back(cyc); wr_gnt_q.push_back(hs); wr_dat_q.push_back(bus.FifoDataIn);
        void'(prod_q[hs].pop_front());
        fifo_cnt++;
      end else begin
        checks++;
        if (bus.FifoDataIn !== '0) begin errors++; $display("FAIL data_idle: got %h required 00", bus.FifoDataIn); end
      end
      if (err_cyc >= 0 && cyc > err_cyc) begin
        checks++;
        if (nready != 0 || bus.FifoWriteEn !== 1'b0 || bus.ErrorSticky !== 1'b1) begin
          errors++; $display("FAIL error_block: ready=%b wr=%b sticky=%b required 0/0/1", bus.ReqReady, bus.FifoWriteEn, bus.ErrorSticky);
        end
      end
      if (c0 > 0 && $urandom_range(99) < read_pct) fifo_cnt--;
      cyc++;
      if (drain) begin
        empty = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) if (prod_q[i].size() > 0) empty = 1'b0;
        if (empty && exp_q.size() == 0) tail++;
        if (tail >= 3) done = 1'b1;
        if (!done && cyc >= max_cyc) begin
          errors++; $display("FAIL drain_timeout: %0d words outstanding after %0d cycles", exp_q.size(), cyc);
          done = 1'b1;
        end
      end else if (cyc >= max_cyc) begin
        done = 1'b1;
      end
    end
    if (drain) begin
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL missing_words: %0d outstanding required 0", exp_q.size()); end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    bus.ReqValid = '1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (bus.ReqReady !== '0 || bus.FifoWriteEn !== 1'b0 || bus.FifoDataIn !== '0 || bus.Busy !== 1'b0 ||
        bus.GrantId !== '0 || bus.ErrorSticky !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: ready=%b wr=%b data=%h busy=%b gnt=%0d sticky=%b required all 0",
               bus.ReqReady, bus.FifoWriteEn, bus.FifoDataIn, bus.Busy, bus.GrantId, bus.ErrorSticky);
    end
    apply_reset();
  endtask

  task automatic test_single_burst();
    int exp_cyc [6] = '{1, 2, 3, 4, 6, 7};
    apply_reset();
    for (int i = 0; i < 6; i++) prod_q[0].push_back(DW'(8'hA0 + i));
    run_stream(60, 100, 1);
    checks++;
    if (wr_cyc_q.size() != 6) begin
      errors++; $display("FAIL single_count: got %0d writes required 6", wr_cyc_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (wr_cyc_q[i] != exp_cyc[i]) begin errors++; $display("FAIL single_timing: word %0d at cycle %0d required %0d", i, wr_cyc_q[i], exp_cyc[i]); end
      end
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    for (int i = 0; i < NUM_REQ; i++)
      for (int j = 0; j < 6; j++) prod_q[i].push_back(DW'($urandom));
    run_stream(300, 100, 1);
    checks++;
    if (wr_gnt_q.size() != 24) begin
      errors++; $display("FAIL rr_count: got %0d writes required 24", wr_gnt_q.size());
    end else begin
      for (int b = 0; b < 4; b++) begin
        checks++;
        if (wr_gnt_q[b*4] != b || wr_cyc_q[b*4+3] - wr_cyc_q[b*4] != 3) begin
          errors++; $display("FAIL rr_burst: burst %0d grant %0d span %0d required grant %0d span 3",
                             b, wr_gnt_q[b*4], wr_cyc_q[b*4+3] - wr_cyc_q[b*4], b);
        end
        if (b < 3) begin
          checks++;
          if (wr_cyc_q[b*4+4] - wr_cyc_q[b*4+3] != 2) begin
            errors++; $display("FAIL rr_gap: gap %0d after burst %0d required 2", wr_cyc_q[b*4+4] - wr_cyc_q[b*4+3], b);
          end
        end
      end
    end
  endtask

  task automatic test_full_backpressure();
    apply_reset();
    fifo_cnt = DEPTH;
    prod_q[2].push_back(8'h5C);
    run_stream(6, 0, 0);
    checks++;
    if (wr_cyc_q.size() != 0 || bus.Busy !== 1'b1 || bus.GrantId !== GW'(2) || bus.ReqReady[2] !== 1'b0) begin
      errors++; $display("FAIL full_hold: writes=%0d busy=%b gnt=%0d ready2=%b required 0/1/2/0",
                         wr_cyc_q.size(), bus.Busy, bus.GrantId, bus.ReqReady[2]);
    end
    fifo_cnt = DEPTH - 1;
    run_stream(40, 0, 1);
    checks++;
    if (wr_dat_q.size() != 1 || fifo_cnt != DEPTH) begin
      errors++; $display("FAIL full_resume: writes=%0d occupancy=%0d required 1/%0d", wr_dat_q.size(), fifo_cnt, DEPTH);
    end
  endtask

  task automatic test_error();
    apply_reset();
    for (int j = 0; j < 8; j++) prod_q[1].push_back(DW'($urandom));
    err_cyc = 3;
    run_stream(10, 100, 0);
    err_cyc = -1;
    checks++;
    if (wr_dat_q.size() != 3 || bus.ErrorSticky !== 1'b1) begin
      errors++; $display("FAIL error_stop: writes=%0d sticky=%b required 3/1", wr_dat_q.size(), bus.ErrorSticky);
    end
    apply_reset();
    #1;
    checks++;
    if (bus.ErrorSticky !== 1'b0) begin errors++; $display("FAIL error_clear: sticky=%b required 0", bus.ErrorSticky); end
    for (int j = 0; j < 3; j++) prod_q[1].push_back(DW'($urandom));
    run_stream(40, 100, 1);
    checks++;
    if (wr_dat_q.size() != 3) begin errors++; $display("FAIL error_resume: writes=%0d required 3", wr_dat_q.size()); end
  endtask

  task automatic test_reset_mid_burst();
    logic [DW-1:0] w;
    apply_reset();
    for (int j = 0; j < 8; j++) prod_q[0].push_back(DW'($urandom));
    for (int j = 0; j < 2; j++) prod_q[3].push_back(DW'($urandom));
    run_stream(3, 100, 0);
    @(negedge clk);
    drive_inputs(0);
    #1;
    checks++;
    if (bus.FifoWriteEn !== 1'b1) begin errors++; $display("FAIL mid_burst_active: wr=%b required 1", bus.FifoWriteEn); end
    w = prod_q[0][0];
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.FifoWriteEn !== 1'b0 || bus.ReqReady !== '0 || bus.FifoDataIn !== '0 || bus.Busy !== 1'b0) begin
      errors++; $display("FAIL async_reset: wr=%b ready=%b data=%h busy=%b required 0", bus.FifoWriteEn, bus.ReqReady, bus.FifoDataIn, bus.Busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_rr = 0;
    run_stream(200, 100, 1);
    checks++;
    if (wr_gnt_q.size() == 0 || wr_gnt_q[0] != 0 || wr_dat_q[0] !== w) begin
      errors++; $display("FAIL reset_retry: first write req %0d data %h required req 0 data %h",
                         (wr_gnt_q.size() > 0) ? wr_gnt_q[0] : -1, (wr_dat_q.size() > 0) ? wr_dat_q[0] : 8'h00, w);
    end
  endtask

  task automatic test_random();
    int n;
    apply_reset();
    for (int it = 0; it < 20; it++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        n = $urandom_range(0, 9);
        for (int j = 0; j < n; j++) prod_q[i].push_back(DW'($urandom));
      end
      run_stream(2000, $urandom_range(20, 100), 1);
    end
  endtask

`ifdef FIFO_ARB_WMARK_EN
  task automatic test_wmark();
    apply_reset();
    hf_n = 1'b0;
    for (int j = 0; j < 3; j++) begin
      prod_q[1].push_back(DW'($urandom));
      prod_q[2].push_back(DW'($urandom));
    end
    run_stream(5, 0, 0);
    checks++;
    if (wr_dat_q.size() != 0 || bus.Busy !== 1'b0) begin
      errors++; $display("FAIL wmark_block: writes=%0d busy=%b required 0/0", wr_dat_q.size(), bus.Busy);
    end
    prod_q[0].push_back(DW'($urandom));
    prod_q[0].push_back(DW'($urandom));
    run_stream(6, 0, 0);
    checks++;
    if (wr_gnt_q.size() != 2 || wr_gnt_q[0] != 0 || wr_gnt_q[1] != 0) begin
      errors++; $display("FAIL wmark_req0: writes=%0d required 2 from req 0", wr_gnt_q.size());
    end
    hf_n = 1'b1;
    m_rr = 1;
    run_stream(100, 100, 1);
    checks++;
    if (wr_gnt_q.size() == 0 || wr_gnt_q[0] != 1) begin
      errors++; $display("FAIL wmark_release: first grant %0d required 1", (wr_gnt_q.size() > 0) ? wr_gnt_q[0] : -1);
    end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    idle_inputs();
    test_reset();
    test_single_burst();
    test_round_robin();
    test_full_backpressure();
    test_error();
    test_reset_mid_burst();
    test_random();
`ifdef FIFO_ARB_WMARK_EN
    test_wmark();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
